exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 Parameters: none; all widths fixed (data 32 bits, shamt 5, alu_op 4, func 6, operation 5).
REQ-002 clk  in  1  single clock; all registered outputs update on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 en  in  1  output-register load enable; 0 holds registered outputs (pipeline stall).
REQ-005 alu_op  in  4  ALU operation class from the control unit.
REQ-006 func  in  6  R-type function field.
REQ-007 op1, op2  in  32 each  forwarded source operands (op1 = rs value; op2 = rt value or extended immediate).
REQ-008 shamt  in  5  R-type shift amount.
REQ-009 pc_plus4  in  32  PC+4 of the instruction in this stage.
REQ-010 imm_ext  in  32  extended 16-bit immediate.
REQ-011 alu_out  out  32  combinational ALU result.
REQ-012 operation  out  5  combinational decoded ALU operation code.
REQ-013 result_q, branch_addr_q  out  32 each  registered ALU result and branch target.
REQ-014 zero_q, overflow_q  out  1 each  registered zero and signed-overflow flags.

Function
REQ-015 alu_op decode: 0000 use func; 0001 ADD; 0010 SUB; 0011 AND; 0100 OR; 0101 XOR; 0110 SLT; 0111 SLTU; 1000 LUI; 1001-1111 ADD.
REQ-016 Operation codes: ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, NOR 00101, SLT 00110, SLTU 00111, SLL 01000, SRL 01001, SRA 01010, SLLV 01011, SRLV 01100, SRAV 01101, LUI 01110, ADDU 01111, SUBU 10000.
REQ-017 func decode (alu_op=0000): 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU, 0x00 SLL, 0x02 SRL, 0x03 SRA, 0x04 SLLV, 0x06 SRLV, 0x07 SRAV; any other func -> ADD.
REQ-018 ADD/ADDU: op1+op2 mod 2^32; SUB/SUBU: op1-op2 mod 2^32.
REQ-019 AND/OR/XOR/NOR bitwise on op1, op2.
REQ-020 SLT: 1 if signed op1 < signed op2 else 0; SLTU same unsigned; upper 31 bits zero.
REQ-021 SLL/SRL/SRA: op2 shifted by shamt; SLLV/SRLV/SRAV: op2 shifted by op1[4:0]; SRA/SRAV replicate op2[31].
REQ-022 LUI: {op2[15:0], 16'h0000}.
REQ-023 Overflow = 1 only for ADD (operands same sign, result sign differs) and SUB (operand signs differ, result sign differs from op1); 0 for ADDU, SUBU and all others.
REQ-024 Zero = 1 iff alu_out == 0.
REQ-025 Branch target = pc_plus4 + (imm_ext << 2), mod 2^32 (wraps, no flag).
REQ-026 alu_out, operation purely combinational from current inputs, zero cycles latency.
REQ-027 On rising clk with en=1: result_q<=alu_out, zero_q<=zero, overflow_q<=overflow, branch_addr_q<=target; one-cycle latency.
REQ-028 en=0: all registered outputs hold.

Reset
REQ-029 rst_n=0 immediately (no clock) clears result_q, branch_addr_q to 0, zero_q, overflow_q to 0; registers hold reset while rst_n=0, regardless of en.
REQ-030 Combinational outputs unaffected by reset; first load occurs on first rising clk with rst_n=1 and en=1.

Verification
REQ-031 alu_op=0000, func=0x20, op1=10, op2=5, en=1, clk -> alu_out=15, result_q=15, zero_q=0, overflow_q=0.
REQ-032 alu_op=0010, op1=op2=7 -> alu_out=0, zero=1; alu_op=0110, op1=0xFFFFFFFF, op2=1 -> 1; alu_op=0111 same operands -> 0.
REQ-033 func=0x20, op1=0x7FFFFFFF, op2=1 -> alu_out=0x80000000, overflow_q=1; func=0x21 same -> overflow_q=0.
REQ-034 func=0x03, op2=0x80000000, shamt=4 -> 0xF8000000; func=0x04, op1=3, op2=1 -> 8; alu_op=1000, op2=0x1234 -> 0x12340000.
REQ-035 pc_plus4=100, imm_ext=0xFFFFFFFF -> branch_addr_q=96; imm_ext=2 -> 108.
REQ-036 Load result_q=15, assert rst_n=0 mid-cycle -> all registered outputs 0 immediately; then en=0 after release -> outputs stay 0.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: ALU, flag generation and branch-target adder. alu_out/operation are combinational;
// result/flags/target are registered one cycle later; en=0 stalls (holds) the output register.
module exe_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [3:0]  alu_op,
    input  logic [5:0]  func,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [4:0]  shamt,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] imm_ext,
    output logic [31:0] alu_out,
    output logic [4:0]  operation,
    output logic [31:0] result_q,
    output logic [31:0] branch_addr_q,
    output logic        zero_q,
    output logic        overflow_q
);

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000,
        OP_SUB  = 5'b00001,
        OP_AND  = 5'b00010,
        OP_OR   = 5'b00011,
        OP_XOR  = 5'b00100,
        OP_NOR  = 5'b00101,
        OP_SLT  = 5'b00110,
        OP_SLTU = 5'b00111,
        OP_SLL  = 5'b01000,
        OP_SRL  = 5'b01001,
        OP_SRA  = 5'b01010,
        OP_SLLV = 5'b01011,
        OP_SRLV = 5'b01100,
        OP_SRAV = 5'b01101,
        OP_LUI  = 5'b01110,
        OP_ADDU = 5'b01111,
        OP_SUBU = 5'b10000
    } alu_opc_t;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] branch_addr;
        logic        zero;
        logic        overflow;
    } exe_res_t;

    alu_opc_t    op_sel;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [4:0]  sh_amt;
    logic        slt_s;
    logic        slt_u;
    logic        ovf;
    logic [31:0] target;
    exe_res_t    res_nxt;
    exe_res_t    res_q;

    // Operation decode: alu_op selects a class; class 0000 defers to the R-type func field.
    always_comb begin
        op_sel = OP_ADD;
        case (alu_op)
            4'b0000: begin
                case (func)
                    6'h20:   op_sel = OP_ADD;
                    6'h21:   op_sel = OP_ADDU;
                    6'h22:   op_sel = OP_SUB;
                    6'h23:   op_sel = OP_SUBU;
                    6'h24:   op_sel = OP_AND;
                    6'h25:   op_sel = OP_OR;
                    6'h26:   op_sel = OP_XOR;
                    6'h27:   op_sel = OP_NOR;
                    6'h2A:   op_sel = OP_SLT;
                    6'h2B:   op_sel = OP_SLTU;
                    6'h00:   op_sel = OP_SLL;
                    6'h02:   op_sel = OP_SRL;
                    6'h03:   op_sel = OP_SRA;
                    6'h04:   op_sel = OP_SLLV;
                    6'h06:   op_sel = OP_SRLV;
                    6'h07:   op_sel = OP_SRAV;
                    default: op_sel = OP_ADD;
                endcase
            end
            4'b0001: op_sel = OP_ADD;
            4'b0010: op_sel = OP_SUB;
            4'b0011: op_sel = OP_AND;
            4'b0100: op_sel = OP_OR;
            4'b0101: op_sel = OP_XOR;
            4'b0110: op_sel = OP_SLT;
            4'b0111: op_sel = OP_SLTU;
            4'b1000: op_sel = OP_LUI;
            default: op_sel = OP_ADD;
        endcase
    end

    assign operation = op_sel;
    assign sum       = op1 + op2;
    assign diff      = op1 - op2;
    assign slt_s     = $signed(op1) < $signed(op2);
    assign slt_u     = op1 < op2;

    // Variable shifts take their distance from the low five bits of rs.
    assign sh_amt = (op_sel == OP_SLLV || op_sel == OP_SRLV || op_sel == OP_SRAV) ? op1[4:0] : shamt;

    always_comb begin
        alu_out = 32'd0;
        ovf     = 1'b0;
        case (op_sel)
            OP_ADD: begin
                alu_out = sum;
                ovf     = (op1[31] == op2[31]) && (sum[31] != op1[31]);
            end
            OP_ADDU: alu_out = sum;
            OP_SUB: begin
                alu_out = diff;
                ovf     = (op1[31] != op2[31]) && (diff[31] != op1[31]);
            end
            OP_SUBU: alu_out = diff;
            OP_AND:  alu_out = op1 & op2;
            OP_OR:   alu_out = op1 | op2;
            OP_XOR:  alu_out = op1 ^ op2;
            OP_NOR:  alu_out = ~(op1 | op2);
            OP_SLT:  alu_out = {31'd0, slt_s};
            OP_SLTU: alu_out = {31'd0, slt_u};
            OP_SLL, OP_SLLV: alu_out = op2 << sh_amt;
            OP_SRL, OP_SRLV: alu_out = op2 >> sh_amt;
            OP_SRA, OP_SRAV: alu_out = $unsigned($signed(op2) >>> sh_amt);
            OP_LUI:  alu_out = {op2[15:0], 16'h0000};
            default: alu_out = sum;
        endcase
    end

    assign target = pc_plus4 + {imm_ext[29:0], 2'b00};

    always_comb begin
        res_nxt.result      = alu_out;
        res_nxt.branch_addr = target;
        res_nxt.zero        = (alu_out == 32'd0);
        res_nxt.overflow    = ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (en) begin
            res_q <= res_nxt;
        end
    end

    assign result_q      = res_q.result;
    assign branch_addr_q = res_q.branch_addr;
    assign zero_q        = res_q.zero;
    assign overflow_q    = res_q.overflow;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed vectors plus randomized traffic against an arithmetic reference model.
module tb_exe_stage;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  alu_op;
    logic [5:0]  func;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  shamt;
    logic [31:0] pc_plus4;
    logic [31:0] imm_ext;
    logic [31:0] alu_out;
    logic [4:0]  operation;
    logic [31:0] result_q;
    logic [31:0] branch_addr_q;
    logic        zero_q;
    logic        overflow_q;

    int n_checks;
    int n_bad;

    // Expected registered state, advanced by the model.
    logic [31:0] exp_res;
    logic [31:0] exp_br;
    logic        exp_zero;
    logic        exp_ovf;

    exe_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .alu_op        (alu_op),
        .func          (func),
        .op1           (op1),
        .op2           (op2),
        .shamt         (shamt),
        .pc_plus4      (pc_plus4),
        .imm_ext       (imm_ext),
        .alu_out       (alu_out),
        .operation     (operation),
        .result_q      (result_q),
        .branch_addr_q (branch_addr_q),
        .zero_q        (zero_q),
        .overflow_q    (overflow_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] ref_op(input logic [3:0] a, input logic [5:0] f);
        if (a == 4'd0) begin
            case (f)
                6'h20: return 5'd0;
                6'h21: return 5'd15;
                6'h22: return 5'd1;
                6'h23: return 5'd16;
                6'h24: return 5'd2;
                6'h25: return 5'd3;
                6'h26: return 5'd4;
                6'h27: return 5'd5;
                6'h2A: return 5'd6;
                6'h2B: return 5'd7;
                6'h00: return 5'd8;
                6'h02: return 5'd9;
                6'h03: return 5'd10;
                6'h04: return 5'd11;
                6'h06: return 5'd12;
                6'h07: return 5'd13;
                default: return 5'd0;
            endcase
        end
        case (a)
            4'd1: return 5'd0;
            4'd2: return 5'd1;
            4'd3: return 5'd2;
            4'd4: return 5'd3;
            4'd5: return 5'd4;
            4'd6: return 5'd6;
            4'd7: return 5'd7;
            4'd8: return 5'd14;
            default: return 5'd0;
        endcase
    endfunction

    // Result computed with wide integer arithmetic rather than bit operators where possible.
    function automatic logic [31:0] ref_res(input logic [4:0] opc, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sa);
        longint ua, ub, sa_, sb, p, r;
        int     sh;
        ua  = longint'(a);
        ub  = longint'(b);
        sa_ = longint'($signed(a));
        sb  = longint'($signed(b));
        sh  = (opc >= 5'd11 && opc <= 5'd13) ? int'(a[4:0]) : int'(sa);
        p   = longint'(1) << sh;
        case (opc)
            5'd0, 5'd15: r = ua + ub;
            5'd1, 5'd16: r = ua - ub + (longint'(1) << 32);
            5'd2:  r = longint'(a & b);
            5'd3:  r = longint'(a | b);
            5'd4:  r = longint'(a ^ b);
            5'd5:  r = longint'(~(a | b));
            5'd6:  r = (sa_ < sb) ? 1 : 0;
            5'd7:  r = (ua < ub) ? 1 : 0;
            5'd8, 5'd11:  r = ub * p;
            5'd9, 5'd12:  r = ub / p;
            5'd10, 5'd13: r = (sb >= 0) ? sb / p : -((-sb + p - 1) / p);
            5'd14: r = (ub % 65536) * 65536;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    function automatic logic ref_ovf(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b);
        longint s;
        if (opc == 5'd0)      s = longint'($signed(a)) + longint'($signed(b));
        else if (opc == 5'd1) s = longint'($signed(a)) - longint'($signed(b));
        else return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    function automatic logic [31:0] ref_br(input logic [31:0] pc, input logic [31:0] imm);
        longint t;
        t = longint'(pc) + longint'($signed(imm)) * 4;
        return t[31:0];
    endfunction

    task automatic drive(input logic [3:0] a, input logic [5:0] f, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] s);
        alu_op = a;
        func   = f;
        op1    = x;
        op2    = y;
        shamt  = s;
    endtask

    // Advances the registered-output model from the currently driven inputs.
    task automatic model_clock();
        logic [4:0] opc;
        opc = ref_op(alu_op, func);
        if (rst_n && en) begin
            exp_res  = ref_res(opc, op1, op2, shamt);
            exp_br   = ref_br(pc_plus4, imm_ext);
            exp_zero = (exp_res == 32'd0);
            exp_ovf  = ref_ovf(opc, op1, op2);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        drive(4'd1, 6'h20, 32'd3, 32'd4, 5'd0);
        pc_plus4 = 32'd100;
        imm_ext = 32'd1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({result_q, branch_addr_q, zero_q, overflow_q} !== 66'd0) begin
            n_bad++;
            $display("FAIL reset_regs got=%h/%h/%b/%b exp=0", result_q, branch_addr_q, zero_q, overflow_q);
        end
        n_checks++;
        if (alu_out !== 32'd7) begin
            n_bad++;
            $display("FAIL reset_comb got=%h exp=7", alu_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_res = 0; exp_br = 0; exp_zero = 0; exp_ovf = 0;
    endtask

    task automatic test_directed();
        @(negedge clk);
        en = 1'b1;
        pc_plus4 = 32'd100;
        imm_ext = 32'hFFFF_FFFF;
        drive(4'd0, 6'h20, 32'd10, 32'd5, 5'd0);
        #1;
        n_checks++;
        if (alu_out !== 32'd15 || operation !== 5'd0) begin
            n_bad++;
            $display("FAIL add_comb got=%h op=%h exp=f op=0", alu_out, operation);
        end
        @(posedge clk); #1;
        n_checks++;
        if (result_q !== 32'd15 || zero_q !== 1'b0 || overflow_q !== 1'b0 || branch_addr_q !== 32'd96) begin
            n_bad++;
            $display("FAIL add_regs got=%h z=%b v=%b br=%h exp=f/0/0/60", result_q, zero_q, overflow_q, branch_addr_q);
        end

        @(negedge clk);
        imm_ext = 32'd2;
        drive(4'd2, 6'h3F, 32'd7, 32'd7, 5'd0);
        #1;
        n_checks++;
        if (alu_out !== 32'd0 || operation !== 5'd1) begin
            n_bad++;
            $display("FAIL sub_zero got=%h op=%h exp=0 op=1", alu_out, operation);
        end
        @(posedge clk); #1;
        n_checks++;
        if (zero_q !== 1'b1 || branch_addr_q !== 32'd108) begin
            n_bad++;
            $display("FAIL zero_flag got z=%b br=%h exp z=1 br=6c", zero_q, branch_addr_q);
        end

        @(negedge clk);
        drive(4'd6, 6'h00, 32'hFFFF_FFFF, 32'd1, 5'd0);
        #1;
        n_checks++;
        if (alu_out !== 32'd1) begin
            n_bad++;
            $display("FAIL slt got=%h exp=1", alu_out);
        end
        alu_op = 4'd7;
        #1;
        n_checks++;
        if (alu_out !== 32'd0 || operation !== 5'd7) begin
            n_bad++;
            $display("FAIL sltu got=%h op=%h exp=0 op=7", alu_out, operation);
        end

        @(negedge clk);
        drive(4'd0, 6'h20, 32'h7FFF_FFFF, 32'd1, 5'd0);
        @(posedge clk); #1;
        n_checks++;
        if (result_q !== 32'h8000_0000 || overflow_q !== 1'b1) begin
            n_bad++;
            $display("FAIL add_ovf got=%h v=%b exp=80000000 v=1", result_q, overflow_q);
        end
        @(negedge clk);
        func = 6'h21;
        @(posedge clk); #1;
        n_checks++;
        if (result_q !== 32'h8000_0000 || overflow_q !== 1'b0) begin
            n_bad++;
            $display("FAIL addu_noovf got=%h v=%b exp=80000000 v=0", result_q, overflow_q);
        end

        @(negedge clk);
        drive(4'd0, 6'h03, 32'd0, 32'h8000_0000, 5'd4);
        #1;
        n_checks++;
        if (alu_out !== 32'hF800_0000) begin
            n_bad++;
            $display("FAIL sra got=%h exp=f8000000", alu_out);
        end
        drive(4'd0, 6'h04, 32'd3, 32'd1, 5'd0);
        #1;
        n_checks++;
        if (alu_out !== 32'd8) begin
            n_bad++;
            $display("FAIL sllv got=%h exp=8", alu_out);
        end
        drive(4'd8, 6'h00, 32'd0, 32'h0000_1234, 5'd0);
        #1;
        n_checks++;
        if (alu_out !== 32'h1234_0000 || operation !== 5'd14) begin
            n_bad++;
            $display("FAIL lui got=%h op=%h exp=12340000 op=e", alu_out, operation);
        end
        model_clock();
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] specials [4];
        logic [5:0]  funcs [16];
        logic [4:0]  opc;
        specials = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        funcs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                  6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            alu_op = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            func   = ($urandom_range(0, 7) == 0) ? 6'($urandom) : funcs[$urandom_range(0, 15)];
            op1    = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            op2    = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 9) == 0) op2 = op1;
            shamt    = 5'($urandom);
            pc_plus4 = $urandom;
            imm_ext  = ($urandom_range(0, 1) == 0) ? {{16{1'b1}}, 16'($urandom)} : $urandom;
            en       = ($urandom_range(0, 3) != 0);
            #1;
            opc = ref_op(alu_op, func);
            n_checks++;
            if (operation !== opc || alu_out !== ref_res(opc, op1, op2, shamt)) begin
                n_bad++;
                $display("FAIL rand_comb[%0d] a=%h f=%h got=%h/%h exp=%h/%h", i, alu_op, func,
                         operation, alu_out, opc, ref_res(opc, op1, op2, shamt));
            end
            model_clock();
            @(posedge clk); #1;
            n_checks++;
            if (result_q !== exp_res || branch_addr_q !== exp_br || zero_q !== exp_zero || overflow_q !== exp_ovf) begin
                n_bad++;
                $display("FAIL rand_regs[%0d] en=%b got=%h/%h/%b/%b exp=%h/%h/%b/%b", i, en,
                         result_q, branch_addr_q, zero_q, overflow_q, exp_res, exp_br, exp_zero, exp_ovf);
            end
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        en = 1'b1;
        drive(4'd3, 6'h00, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0);
        pc_plus4 = 32'h1000;
        imm_ext = 32'd16;
        model_clock();
        @(posedge clk); #1;
        @(negedge clk);
        en = 1'b0;
        drive(4'd4, 6'h00, 32'h1, 32'h2, 5'd0);
        pc_plus4 = 32'h2000;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (result_q !== 32'h00F0_1234 || branch_addr_q !== 32'h1040 || zero_q !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_hold got=%h/%h/%b exp=00f01234/1040/0", result_q, branch_addr_q, zero_q);
        end
    endtask

    task automatic test_reset_midcycle();
        @(negedge clk);
        en = 1'b1;
        drive(4'd0, 6'h20, 32'd10, 32'd5, 5'd0);
        pc_plus4 = 32'd100;
        imm_ext = 32'd2;
        @(posedge clk); #1;
        n_checks++;
        if (result_q !== 32'd15) begin
            n_bad++;
            $display("FAIL mid_load got=%h exp=f", result_q);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({result_q, branch_addr_q, zero_q, overflow_q} !== 66'd0) begin
            n_bad++;
            $display("FAIL mid_reset got=%h/%h/%b/%b exp=0", result_q, branch_addr_q, zero_q, overflow_q);
        end
        @(posedge clk); #1;
        n_checks++;
        if (result_q !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_hold_en got=%h exp=0", result_q);
        end
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({result_q, branch_addr_q, zero_q, overflow_q} !== 66'd0) begin
            n_bad++;
            $display("FAIL post_release got=%h/%h/%b/%b exp=0", result_q, branch_addr_q, zero_q, overflow_q);
        end
    endtask

    initial begin
        n_checks = 0;
        n_bad = 0;
        rst_n = 1'b0;
        en = 1'b0;
        alu_op = 4'd0;
        func = 6'h20;
        op1 = 32'd0;
        op2 = 32'd0;
        shamt = 5'd0;
        pc_plus4 = 32'd0;
        imm_ext = 32'd0;
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_reset_midcycle();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
